// File: rtl/bomb_countdown_if.sv
// Tick link between the second/half-second tick generator and the countdown.
// The generator drives the elapsed pulses and the countdown drives enable/clear.
interface bomb_countdown_if;
  logic timer_enable;
  logic timer_clear;
  logic second_elapsed;
  logic half_second_elapsed;

  modport master (
    output second_elapsed,
    output half_second_elapsed,
    input  timer_enable,
    input  timer_clear
  );

  modport slave (
    input  second_elapsed,
    input  half_second_elapsed,
    output timer_enable,
    output timer_clear
  );
endinterface

// File: rtl/bomb_countdown.sv
// BCD M:SS bomb countdown: arms from load values, decrements on second ticks,
// and resolves to EXPLODED at 0:00 or DEFUSED on request.
module bomb_countdown (
  input  logic             clk,
  input  logic             sync_reset,
  bomb_countdown_if.slave  tick_if,
  input  logic             arm_i,
  input  logic             defuse_i,
  input  logic [3:0]       load_min_i,
  input  logic [2:0]       load_sec_tens_i,
  input  logic [3:0]       load_sec_ones_i,
  output logic [3:0]       min_digit_o,
  output logic [2:0]       sec_tens_o,
  output logic [3:0]       sec_ones_o,
  output logic [1:0]       state_o,
  output logic             blink_o,
  output logic             warning_o,
  output logic             load_error_o
);

  localparam int unsigned MinW  = 4;
  localparam int unsigned TensW = 3;
  localparam int unsigned OnesW = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_EXPLODED = 2'd2,
    ST_DEFUSED  = 2'd3
  } state_e;

  state_e             state_q;
  logic [MinW-1:0]    min_q;
  logic [TensW-1:0]   tens_q;
  logic [OnesW-1:0]   ones_q;
  logic               blink_q;
  logic               load_error_q;

  logic               load_valid;
  logic               at_one_sec;
  logic               warning_c;
  logic [MinW-1:0]    dec_min;
  logic [TensW-1:0]   dec_tens;
  logic [OnesW-1:0]   dec_ones;

  // A zero start time is rejected: the bomb would explode without ever counting.
  assign load_valid = (load_min_i <= MinW'(9)) && (load_sec_tens_i <= TensW'(5)) &&
                      (load_sec_ones_i <= OnesW'(9)) &&
                      (|{load_min_i, load_sec_tens_i, load_sec_ones_i});

  assign at_one_sec = (min_q == '0) && (tens_q == '0) && (ones_q == OnesW'(1));

  assign warning_c  = (state_q == ST_ARMED) && (min_q == '0) &&
                      ((tens_q == '0) || ((tens_q == TensW'(1)) && (ones_q == '0)));

  // One-second BCD decrement with borrow through tens and minutes.
  always_comb begin
    dec_min  = min_q;
    dec_tens = tens_q;
    dec_ones = ones_q;
    if (ones_q != '0) begin
      dec_ones = ones_q - OnesW'(1);
    end else if (tens_q != '0) begin
      dec_ones = OnesW'(9);
      dec_tens = tens_q - TensW'(1);
    end else begin
      dec_ones = OnesW'(9);
      dec_tens = TensW'(5);
      dec_min  = min_q - MinW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q      <= ST_IDLE;
      min_q        <= '0;
      tens_q       <= '0;
      ones_q       <= '0;
      blink_q      <= 1'b1;
      load_error_q <= 1'b0;
    end else begin
      load_error_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          blink_q <= 1'b1;
          if (arm_i) begin
            if (load_valid) begin
              state_q <= ST_ARMED;
              min_q   <= load_min_i;
              tens_q  <= load_sec_tens_i;
              ones_q  <= load_sec_ones_i;
            end else begin
              load_error_q <= 1'b1;
            end
          end
        end

        ST_ARMED: begin
          if (defuse_i) begin
            // Defuse beats a coincident tick, freezing the displayed time.
            state_q <= ST_DEFUSED;
            blink_q <= 1'b1;
          end else if (tick_if.second_elapsed && at_one_sec) begin
            state_q <= ST_EXPLODED;
            min_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            blink_q <= 1'b1;
          end else begin
            if (tick_if.second_elapsed) begin
              min_q  <= dec_min;
              tens_q <= dec_tens;
              ones_q <= dec_ones;
            end
            if (warning_c && tick_if.half_second_elapsed) begin
              blink_q <= ~blink_q;
            end
          end
        end

        ST_EXPLODED: begin
          if (tick_if.half_second_elapsed) begin
            blink_q <= ~blink_q;
          end
        end

        ST_DEFUSED: begin
          blink_q <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Tick generator runs while counting or flashing, and is held clear otherwise.
  assign tick_if.timer_enable = (state_q == ST_ARMED) || (state_q == ST_EXPLODED);
  assign tick_if.timer_clear  = (state_q == ST_IDLE)  || (state_q == ST_DEFUSED);

  assign min_digit_o  = min_q;
  assign sec_tens_o   = tens_q;
  assign sec_ones_o   = ones_q;
  assign state_o      = state_q;
  assign blink_o      = blink_q;
  assign warning_o    = warning_c;
  assign load_error_o = load_error_q;

endmodule

// File: tb/tb_bomb_countdown.sv
// Directed bench for bomb_countdown: each task drives one scenario and checks inline.
module tb_bomb_countdown;

  logic       clk = 1'b0;
  logic       sync_reset;
  logic       arm;
  logic       defuse;
  logic [3:0] lmin;
  logic [2:0] ltens;
  logic [3:0] lones;
  logic [3:0] min_digit;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] state;
  logic       blink;
  logic       warning;
  logic       load_error;

  int n_checks = 0;
  int n_fail   = 0;

  bomb_countdown_if tif ();

  bomb_countdown dut (
    .clk             (clk),
    .sync_reset      (sync_reset),
    .tick_if         (tif.slave),
    .arm_i           (arm),
    .defuse_i        (defuse),
    .load_min_i      (lmin),
    .load_sec_tens_i (ltens),
    .load_sec_ones_i (lones),
    .min_digit_o     (min_digit),
    .sec_tens_o      (sec_tens),
    .sec_ones_o      (sec_ones),
    .state_o         (state),
    .blink_o         (blink),
    .warning_o       (warning),
    .load_error_o    (load_error)
  );

  always #5 clk = ~clk;

  wire [10:0] digits = {min_digit, sec_tens, sec_ones};

  function automatic logic [10:0] bcd(input int m, input int t, input int o);
    return {4'(m), 3'(t), 4'(o)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
  endtask

  task automatic do_arm(input int m, input int t, input int o);
    lmin  = 4'(m);
    ltens = 3'(t);
    lones = 4'(o);
    arm   = 1'b1;
    step();
    arm   = 1'b0;
  endtask

  task automatic tick(input logic sec, input logic half);
    tif.second_elapsed      = sec;
    tif.half_second_elapsed = half;
    step();
    tif.second_elapsed      = 1'b0;
    tif.half_second_elapsed = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", state); end
    n_checks++; if (digits !== bcd(0,0,0)) begin n_fail++; $display("FAIL reset_digits: got %0d:%0d%0d exp 0:00", min_digit, sec_tens, sec_ones); end
    n_checks++; if ({blink, load_error, tif.timer_clear, tif.timer_enable, warning} !== 5'b10100) begin n_fail++; $display("FAIL reset_flags: got %b exp 10100", {blink, load_error, tif.timer_clear, tif.timer_enable, warning}); end
    // Ticks and defuse do nothing while idle
    defuse = 1'b1; tick(1'b1, 1'b1); defuse = 1'b0;
    n_checks++; if (state !== 2'd0 || digits !== bcd(0,0,0)) begin n_fail++; $display("FAIL idle_ignore: got state %0d digits %h exp 0 / 000", state, digits); end
  endtask

  task automatic test_explode();
    logic exp_blink;
    do_reset();
    do_arm(0, 0, 3);
    n_checks++; if (state !== 2'd1 || digits !== bcd(0,0,3)) begin n_fail++; $display("FAIL arm3_load: got state %0d %0d:%0d%0d exp 1 0:03", state, min_digit, sec_tens, sec_ones); end
    n_checks++; if ({tif.timer_clear, tif.timer_enable, blink, warning} !== 4'b0111) begin n_fail++; $display("FAIL arm3_flags: got %b exp 0111", {tif.timer_clear, tif.timer_enable, blink, warning}); end
    tick(1'b0, 1'b1);
    n_checks++; if (blink !== 1'b0) begin n_fail++; $display("FAIL arm3_blink_half: got %b exp 0", blink); end
    for (int s = 2; s >= 1; s--) begin
      tick(1'b1, 1'b1);
      n_checks++; if (digits !== bcd(0,0,s) || state !== 2'd1) begin n_fail++; $display("FAIL arm3_dec%0d: got state %0d %0d:%0d%0d", s, state, min_digit, sec_tens, sec_ones); end
      n_checks++; if (blink !== 1'b1) begin n_fail++; $display("FAIL arm3_blink_on%0d: got %b exp 1", s, blink); end
      tick(1'b0, 1'b1);
      n_checks++; if (blink !== 1'b0) begin n_fail++; $display("FAIL arm3_blink_off%0d: got %b exp 0", s, blink); end
    end
    tick(1'b1, 1'b1);
    n_checks++; if (state !== 2'd2 || digits !== bcd(0,0,0)) begin n_fail++; $display("FAIL explode: got state %0d %0d:%0d%0d exp 2 0:00", state, min_digit, sec_tens, sec_ones); end
    n_checks++; if ({tif.timer_clear, tif.timer_enable, blink, warning} !== 4'b0110) begin n_fail++; $display("FAIL explode_flags: got %b exp 0110", {tif.timer_clear, tif.timer_enable, blink, warning}); end
    exp_blink = 1'b1;
    for (int h = 0; h < 3; h++) begin
      tick(1'b0, 1'b1);
      exp_blink = ~exp_blink;
      n_checks++; if (blink !== exp_blink) begin n_fail++; $display("FAIL explode_blink%0d: got %b exp %b", h, blink, exp_blink); end
    end
    do_arm(5, 5, 5); defuse = 1'b1; tick(1'b1, 1'b0); defuse = 1'b0;
    n_checks++; if (state !== 2'd2 || digits !== bcd(0,0,0)) begin n_fail++; $display("FAIL explode_terminal: got state %0d digits %h", state, digits); end
  endtask

  task automatic test_borrow();
    do_reset();
    do_arm(1, 0, 0);
    n_checks++; if (warning !== 1'b0) begin n_fail++; $display("FAIL borrow_warn_100: got %b exp 0", warning); end
    tick(1'b1, 1'b0);
    n_checks++; if (digits !== bcd(0,5,9)) begin n_fail++; $display("FAIL borrow_059: got %0d:%0d%0d exp 0:59", min_digit, sec_tens, sec_ones); end
    for (int i = 0; i < 48; i++) tick(1'b1, 1'b0);
    n_checks++; if (digits !== bcd(0,1,1) || warning !== 1'b0) begin n_fail++; $display("FAIL borrow_011: got %0d:%0d%0d warn %b exp 0:11 0", min_digit, sec_tens, sec_ones, warning); end
    tick(1'b0, 1'b1);
    n_checks++; if (blink !== 1'b1) begin n_fail++; $display("FAIL borrow_noblink: got %b exp 1", blink); end
    tick(1'b1, 1'b0);
    n_checks++; if (digits !== bcd(0,1,0) || warning !== 1'b1) begin n_fail++; $display("FAIL borrow_010: got %0d:%0d%0d warn %b exp 0:10 1", min_digit, sec_tens, sec_ones, warning); end
    tick(1'b0, 1'b1);
    n_checks++; if (blink !== 1'b0) begin n_fail++; $display("FAIL warn_blink_off: got %b exp 0", blink); end
    tick(1'b0, 1'b1);
    n_checks++; if (blink !== 1'b1) begin n_fail++; $display("FAIL warn_blink_on: got %b exp 1", blink); end
  endtask

  task automatic test_defuse();
    do_reset();
    do_arm(0, 0, 5);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    defuse = 1'b1; tick(1'b1, 1'b0); defuse = 1'b0;
    n_checks++; if (state !== 2'd3 || digits !== bcd(0,0,3)) begin n_fail++; $display("FAIL defuse_hold: got state %0d %0d:%0d%0d exp 3 0:03", state, min_digit, sec_tens, sec_ones); end
    n_checks++; if ({tif.timer_clear, tif.timer_enable, blink, warning} !== 4'b1010) begin n_fail++; $display("FAIL defuse_flags: got %b exp 1010", {tif.timer_clear, tif.timer_enable, blink, warning}); end
    do_arm(2, 2, 2); tick(1'b1, 1'b1); defuse = 1'b1; tick(1'b1, 1'b1); defuse = 1'b0;
    n_checks++; if (state !== 2'd3 || digits !== bcd(0,0,3) || blink !== 1'b1) begin n_fail++; $display("FAIL defuse_terminal: got state %0d digits %h blink %b", state, digits, blink); end
    do_reset();
    do_arm(0, 0, 1);
    defuse = 1'b1; tick(1'b1, 1'b1); defuse = 1'b0;
    n_checks++; if (state !== 2'd3 || digits !== bcd(0,0,1)) begin n_fail++; $display("FAIL defuse_at_001: got state %0d %0d:%0d%0d exp 3 0:01", state, min_digit, sec_tens, sec_ones); end
  endtask

  task automatic test_load_error();
    do_reset();
    do_arm(0, 6, 0);
    n_checks++; if (load_error !== 1'b1 || state !== 2'd0 || digits !== bcd(0,0,0)) begin n_fail++; $display("FAIL lerr_tens6: got err %b state %0d digits %h", load_error, state, digits); end
    step();
    n_checks++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL lerr_pulse_width: got %b exp 0", load_error); end
    do_arm(10, 0, 0);
    n_checks++; if (load_error !== 1'b1 || state !== 2'd0 || digits !== bcd(0,0,0)) begin n_fail++; $display("FAIL lerr_min10: got err %b state %0d digits %h", load_error, state, digits); end
    do_arm(0, 0, 0);
    n_checks++; if (load_error !== 1'b1 || state !== 2'd0 || digits !== bcd(0,0,0)) begin n_fail++; $display("FAIL lerr_zero: got err %b state %0d digits %h", load_error, state, digits); end
    do_arm(0, 0, 10);
    n_checks++; if (load_error !== 1'b1 || state !== 2'd0) begin n_fail++; $display("FAIL lerr_ones10: got err %b state %0d", load_error, state); end
    step();
    n_checks++; if (load_error !== 1'b0 || tif.timer_clear !== 1'b1) begin n_fail++; $display("FAIL lerr_after: got err %b clr %b exp 0 1", load_error, tif.timer_clear); end
  endtask

  task automatic test_sync_reset();
    do_reset();
    do_arm(2, 1, 7);
    n_checks++; if (digits !== bcd(2,1,7)) begin n_fail++; $display("FAIL sreset_load: got %0d:%0d%0d exp 2:17", min_digit, sec_tens, sec_ones); end
    do_reset();
    n_checks++; if (state !== 2'd0 || digits !== bcd(0,0,0) || tif.timer_clear !== 1'b1) begin n_fail++; $display("FAIL sreset_mid: got state %0d digits %h clr %b", state, digits, tif.timer_clear); end
    sync_reset = 1'b1; do_arm(3, 3, 3); sync_reset = 1'b0;
    n_checks++; if (state !== 2'd0 || digits !== bcd(0,0,0)) begin n_fail++; $display("FAIL sreset_vs_arm: got state %0d digits %h exp 0 000", state, digits); end
  endtask

  task automatic test_rearm_ignored();
    do_reset();
    do_arm(0, 3, 0);
    do_arm(9, 5, 9);
    n_checks++; if (digits !== bcd(0,3,0) || load_error !== 1'b0 || state !== 2'd1) begin n_fail++; $display("FAIL rearm_ignored: got %0d:%0d%0d err %b state %0d", min_digit, sec_tens, sec_ones, load_error, state); end
    tick(1'b1, 1'b0);
    n_checks++; if (digits !== bcd(0,2,9)) begin n_fail++; $display("FAIL rearm_continue: got %0d:%0d%0d exp 0:29", min_digit, sec_tens, sec_ones); end
  endtask

  initial begin
    sync_reset = 1'b0; arm = 1'b0; defuse = 1'b0;
    lmin = '0; ltens = '0; lones = '0;
    tif.second_elapsed = 1'b0; tif.half_second_elapsed = 1'b0;
    test_reset();
    test_explode();
    test_borrow();
    test_defuse();
    test_load_error();
    test_sync_reset();
    test_rearm_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
